// File: rtl/riscv_dbus_ic.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dbus_ic
// Purpose  : Data-bus interconnect between the CPU data port and N_SLV
//            memory-mapped slaves. A request is latched in IDLE. The upper
//            address bits select a slave, and the selected slave is driven
//            until it acks or the wait-state timeout expires. A one-cycle
//            completion pulse then returns read data and an error flag to
//            the master.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        input   1               clock, rising edge
//   reset_ni     input   1               asynchronous active-low reset
//   m_cen_i      input   1               master request
//   m_wen_i      input   1               1 = write, 0 = read
//   m_addr_i     input   ADDR_W          request address
//   m_wdata_i    input   DATA_W          write data
//   m_be_i       input   DATA_W/8        write byte enables
//   m_rdata_o    output  DATA_W          read data, valid with m_ready_o
//   m_ready_o    output  1               one-cycle completion pulse
//   m_err_o      output  1               decode / timeout error, with m_ready_o
//   s_cen_o      output  N_SLV           one-hot slave select
//   s_wen_o      output  1               registered write strobe (shared)
//   s_addr_o     output  SLV_ADDR_W      registered slave-local address
//   s_wdata_o    output  DATA_W          registered write data
//   s_be_o       output  DATA_W/8        registered byte enables
//   s_rdata_i    input   N_SLV*DATA_W    slave i read data at [i*DATA_W +: DATA_W]
//   s_ack_i      input   N_SLV           slave completion, rdata valid same cycle
// ============================================================================
module riscv_dbus_ic #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int N_SLV      = 2,
    parameter int SLV_ADDR_W = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      m_cen_i,
    input  logic                      m_wen_i,
    input  logic [ADDR_W-1:0]         m_addr_i,
    input  logic [DATA_W-1:0]         m_wdata_i,
    input  logic [DATA_W/8-1:0]       m_be_i,
    output logic [DATA_W-1:0]         m_rdata_o,
    output logic                      m_ready_o,
    output logic                      m_err_o,
    output logic [N_SLV-1:0]          s_cen_o,
    output logic                      s_wen_o,
    output logic [SLV_ADDR_W-1:0]     s_addr_o,
    output logic [DATA_W-1:0]         s_wdata_o,
    output logic [DATA_W/8-1:0]       s_be_o,
    input  logic [N_SLV*DATA_W-1:0]   s_rdata_i,
    input  logic [N_SLV-1:0]          s_ack_i
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = ADDR_W - SLV_ADDR_W;
    localparam int CNT_W = 8;
    // Counter value on the last permitted no-ack ACCESS cycle.
    localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [N_SLV-1:0]        s_cen_q;
    logic                    s_wen_q;
    logic [SLV_ADDR_W-1:0]   s_addr_q;
    logic [DATA_W-1:0]       s_wdata_q;
    logic [BE_W-1:0]         s_be_q;
    logic [DATA_W-1:0]       m_rdata_q;
    logic                    m_ready_q;
    logic                    m_err_q;

    logic [IDX_W-1:0]        slv_idx;
    logic                    idx_ok;
    logic [N_SLV-1:0]        dec_onehot;
    logic                    ack_sel;
    logic [DATA_W-1:0]       rdata_sel;

    assign slv_idx = m_addr_i[ADDR_W-1:SLV_ADDR_W];

    // Address decode. An index with no matching channel leaves idx_ok low,
    // which turns the request into a decode error.
    always_comb begin
        idx_ok     = 1'b0;
        dec_onehot = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (32'(slv_idx) == i) begin
                dec_onehot[i] = 1'b1;
                idx_ok        = 1'b1;
            end
        end
    end

    // s_cen_q is one-hot during ACCESS, so masking it against the inputs
    // picks out only the selected slave. Acks and read data from every
    // other channel drop out here.
    assign ack_sel = |(s_cen_q & s_ack_i);

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (s_cen_q[i]) begin
                rdata_sel = rdata_sel | s_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            s_cen_q   <= '0;
            s_wen_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_be_q    <= '0;
            m_rdata_q <= '0;
            m_ready_q <= 1'b0;
            m_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    m_ready_q <= 1'b0;
                    if (m_cen_i) begin
                        // The request is sampled only here. Later changes
                        // on the master side do not affect this access.
                        s_wen_q   <= m_wen_i;
                        s_addr_q  <= m_addr_i[SLV_ADDR_W-1:0];
                        s_wdata_q <= m_wdata_i;
                        s_be_q    <= m_be_i;
                        cnt_q     <= '0;
                        if (idx_ok) begin
                            s_cen_q <= dec_onehot;
                            state_q <= ST_ACCESS;
                        end else begin
                            m_err_q   <= 1'b1;
                            m_rdata_q <= '0;
                            m_ready_q <= 1'b1;
                            state_q   <= ST_RESP;
                        end
                    end
                end

                ST_ACCESS: begin
                    // An ack in the expiry cycle takes priority over the
                    // timeout.
                    if (ack_sel) begin
                        m_rdata_q <= s_wen_q ? '0 : rdata_sel;
                        m_err_q   <= 1'b0;
                        m_ready_q <= 1'b1;
                        s_cen_q   <= '0;
                        state_q   <= ST_RESP;
                    end else if (cnt_q == C_TO_LAST) begin
                        m_rdata_q <= '0;
                        m_err_q   <= 1'b1;
                        m_ready_q <= 1'b1;
                        s_cen_q   <= '0;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_RESP: begin
                    // One-cycle completion pulse. m_cen is ignored here,
                    // so a new request is never accepted back-to-back.
                    m_ready_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    state_q   <= ST_IDLE;
                    s_cen_q   <= '0;
                    m_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_rdata_o = m_rdata_q;
    assign m_ready_o = m_ready_q;
    assign m_err_o   = m_err_q;
    assign s_cen_o   = s_cen_q;
    assign s_wen_o   = s_wen_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;
    assign s_be_o    = s_be_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_dbus_ic.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_dbus_ic
// Purpose  : Self-checking bench for riscv_dbus_ic. For each transaction a
//            reference model predicts three things: the slave-select
//            window, the cycle of the completion pulse, and the response
//            data and error flag. Slave behaviour and noise on unselected
//            channels are randomised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_dbus_ic;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int N_SLV      = 2;
    localparam int SLV_ADDR_W = 8;
    localparam int TIMEOUT    = 15;
    localparam int BE_W       = DATA_W / 8;
    localparam int NEVER      = 1000;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    m_cen;
    logic                    m_wen;
    logic [ADDR_W-1:0]       m_addr;
    logic [DATA_W-1:0]       m_wdata;
    logic [BE_W-1:0]         m_be;
    logic [DATA_W-1:0]       m_rdata;
    logic                    m_ready;
    logic                    m_err;
    logic [N_SLV-1:0]        s_cen;
    logic                    s_wen;
    logic [SLV_ADDR_W-1:0]   s_addr;
    logic [DATA_W-1:0]       s_wdata;
    logic [BE_W-1:0]         s_be;
    logic [N_SLV*DATA_W-1:0] s_rdata;
    logic [N_SLV-1:0]        s_ack;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    riscv_dbus_ic #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .N_SLV      (N_SLV),
        .SLV_ADDR_W (SLV_ADDR_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .reset_ni  (reset_n),
        .m_cen_i   (m_cen),
        .m_wen_i   (m_wen),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_be_i    (m_be),
        .m_rdata_o (m_rdata),
        .m_ready_o (m_ready),
        .m_err_o   (m_err),
        .s_cen_o   (s_cen),
        .s_wen_o   (s_wen),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_be_o    (s_be),
        .s_rdata_i (s_rdata),
        .s_ack_i   (s_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_master();
        m_cen   = 1'($urandom);
        m_wen   = 1'($urandom);
        m_addr  = ADDR_W'($urandom);
        m_wdata = $urandom;
        m_be    = BE_W'($urandom);
    endtask

    // The slave index is the address divided by the slave window size.
    // ack_delay is the number of wait cycles the selected slave inserts;
    // any value of TIMEOUT or more means the slave never acks.
    task automatic run_txn(input logic wen, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be,
                           input int ack_delay, input logic [DATA_W-1:0] rdata);
        int               idx;
        bit               dec_err;
        bit               timed_out;
        int               acc_len;
        logic [N_SLV-1:0] exp_cen;
        logic [DATA_W-1:0] exp_rd;
        idx       = int'(addr) / (1 << SLV_ADDR_W);
        dec_err   = (idx >= N_SLV);
        timed_out = !dec_err && (ack_delay >= TIMEOUT);
        acc_len   = dec_err ? 0 : (timed_out ? TIMEOUT : ack_delay + 1);
        exp_cen   = dec_err ? '0 : N_SLV'(1 << idx);
        exp_rd    = (dec_err || timed_out || wen) ? '0 : rdata;

        @(negedge clk);
        m_cen = 1'b1; m_wen = wen; m_addr = addr; m_wdata = wdata; m_be = be;
        @(posedge clk);
        for (int c = 1; c <= acc_len + 1; c++) begin
            @(negedge clk);
            randomize_master();
            s_rdata = {$urandom, $urandom};
            if (c <= acc_len) begin
                chk("s_cen",      64'(s_cen),   64'(exp_cen));
                chk("s_wen",      64'(s_wen),   64'(wen));
                chk("s_addr",     64'(s_addr),  64'(addr[SLV_ADDR_W-1:0]));
                chk("s_wdata",    64'(s_wdata), 64'(wdata));
                chk("s_be",       64'(s_be),    64'(be));
                chk("ready_early", 64'(m_ready), 64'd0);
                s_ack = N_SLV'($urandom) & ~exp_cen;
                if (c == ack_delay + 1) begin
                    s_ack = s_ack | exp_cen;
                    s_rdata[idx*DATA_W +: DATA_W] = rdata;
                end
            end else begin
                chk("m_ready",  64'(m_ready), 64'd1);
                chk("m_err",    64'(m_err),   64'(dec_err || timed_out));
                chk("m_rdata",  64'(m_rdata), 64'(exp_rd));
                chk("cen_resp", 64'(s_cen),   64'd0);
                // A request held during RESP must not be accepted.
                m_cen  = 1'b1;
                m_addr = ADDR_W'(0);
                s_ack  = N_SLV'($urandom);
            end
        end
        @(negedge clk);
        chk("ready_pulse", 64'(m_ready), 64'd0);
        chk("no_b2b_cen",  64'(s_cen),   64'd0);
        chk("rdata_hold",  64'(m_rdata), 64'(exp_rd));
        m_cen = 1'b0;
        s_ack = '0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        bit seen_ready;
        int dly;

        // Reset with random inputs applied.
        reset_n = 1'b0;
        randomize_master();
        s_rdata = {$urandom, $urandom};
        s_ack   = N_SLV'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_m_rdata", 64'(m_rdata), 64'd0);
        chk("rst_m_ready", 64'(m_ready), 64'd0);
        chk("rst_m_err",   64'(m_err),   64'd0);
        chk("rst_s_cen",   64'(s_cen),   64'd0);
        chk("rst_s_wen",   64'(s_wen),   64'd0);
        chk("rst_s_addr",  64'(s_addr),  64'd0);
        chk("rst_s_wdata", 64'(s_wdata), 64'd0);
        chk("rst_s_be",    64'(s_be),    64'd0);
        m_cen   = 1'b0;
        s_ack   = '0;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_cen",   64'(s_cen),   64'd0);
            chk("idle_no_ready", 64'(m_ready), 64'd0);
        end

        // Directed cases.
        run_txn(1'b0, 10'h004, 32'h0, 4'hF, 0, 32'hDEADBEEF);            // zero-wait read
        run_txn(1'b1, 10'h120, 32'h12345678, 4'b0011, 3, 32'hCAFEF00D);  // 4-cycle write
        run_txn(1'b0, 10'h010, 32'h0, 4'hF, NEVER, 32'h11111111);        // timeout
        run_txn(1'b0, 10'h0FF, 32'h0, 4'h5, TIMEOUT - 1, 32'hA5A5A5A5);  // ack at expiry wins
        run_txn(1'b0, 10'h300, 32'h0, 4'hF, 0, 32'h22222222);            // decode error
        run_txn(1'b1, 10'h2AB, 32'h55AA55AA, 4'hC, 0, 32'h0);            // decode error, write
        run_txn(1'b0, 10'h1FC, 32'h0, 4'h1, 5, 32'h0BADF00D);            // slave1 read, waits

        // Randomised transactions.
        for (int n = 0; n < 40; n++) begin
            dly = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2))
                                               : int'($urandom_range(0, 6));
            run_txn(1'($urandom), ADDR_W'($urandom), $urandom, BE_W'($urandom), dly, $urandom);
        end

        // Reset in the middle of an access: the select drops asynchronously
        // and the abandoned access never produces a completion.
        @(negedge clk);
        m_cen = 1'b1; m_wen = 1'b0; m_addr = 10'h010; m_wdata = '0; m_be = 4'hF;
        s_ack = '0;
        @(negedge clk);
        m_cen = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_cen_before", 64'(s_cen), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_cen_async",   64'(s_cen),   64'd0);
        chk("mid_ready_async", 64'(m_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen_ready = 1'b0;
        repeat (TIMEOUT + 5) begin
            @(negedge clk);
            seen_ready = seen_ready | m_ready;
        end
        chk("mid_no_ready", 64'(seen_ready), 64'd0);
        chk("mid_no_cen",   64'(s_cen),      64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscv_dbus_ic.md
Name: riscv_dbus_ic

Overview:
- Parametrised data-bus interconnect between the CPU data port and N_SLV memory-mapped slaves (data memory, peripherals).
- Replaces the single direct CPU-to-data-memory connection.
- Adds a request/ready handshake, variable slave wait states, byte enables, address decode and bus-error/timeout reporting.
- The CPU stalls while m_ready is low.

Parameters:
ADDR_W, 10, master byte/word address width
DATA_W, 32, data width; must be a multiple of 8
N_SLV, 2, number of slave channels (1..8)
SLV_ADDR_W, 8, per-slave address width; slave index = m_addr[ADDR_W-1:SLV_ADDR_W]
TIMEOUT, 15, max cycles waiting for s_ack before error (1..255)

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
m_cen  input  1  master request, active-high
m_wen  input  1  1 = write, 0 = read
m_addr  input  ADDR_W  request address
m_wdata  input  DATA_W  write data
m_be  input  DATA_W/8  byte enables for writes
m_rdata  output  DATA_W  read data, valid when m_ready=1
m_ready  output  1  one-cycle completion pulse
m_err  output  1  error flag, valid with m_ready
s_cen  output  N_SLV  one-hot slave select, active-high
s_wen  output  1  registered write strobe (shared)
s_addr  output  SLV_ADDR_W  registered slave-local address (shared)
s_wdata  output  DATA_W  registered write data (shared)
s_be  output  DATA_W/8  registered byte enables (shared)
s_rdata  input  N_SLV*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
s_ack  input  N_SLV  slave completion, one cycle; s_rdata valid in the same cycle

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE and the timeout counter clears.
  - All outputs are 0: m_rdata, m_ready, m_err, s_cen, s_wen, s_addr, s_wdata, s_be.
  - Reset mid-transaction abandons it; no response is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Waits for m_cen=1.
  - On m_cen=1, registers m_wen, m_addr low bits, m_wdata and m_be.
  - Computes idx = m_addr[ADDR_W-1:SLV_ADDR_W].
  - If idx < N_SLV: next state ACCESS, s_cen[idx]=1.
  - If idx >= N_SLV (decode error): next state RESP with m_err=1, m_rdata=0. No slave is selected.
- ACCESS:
  - s_cen stays one-hot on the selected slave; s_* fields stay stable.
  - s_ack of the selected slave=1: capture its s_rdata into m_rdata (0 for writes), m_err=0, clear s_cen, go to RESP.
  - s_ack from non-selected slaves is ignored.
  - The counter increments each ACCESS cycle without ack. On a no-ack cycle with count == TIMEOUT-1: clear s_cen, m_err=1, m_rdata=0, go to RESP. Access therefore lasts at most TIMEOUT cycles.
  - An ack arriving in the same cycle as timeout expiry wins: the access completes normally with m_err=0.
- RESP:
  - m_ready=1 for exactly one cycle; m_rdata and m_err are held valid during it.
  - Next state is IDLE unconditionally. m_cen during RESP is ignored and back-to-back acceptance is not allowed.
  - m_rdata holds its value until the next capture.
- Master rule: m_cen and the request fields are sampled once, at acceptance in IDLE. Later changes, including deasserting m_cen, do not affect the transaction in flight.
- Latency:
  - Zero-wait slave (ack in the first ACCESS cycle): m_ready is high in the 3rd cycle after m_cen is sampled (IDLE → ACCESS → RESP).
  - Each slave wait cycle adds 1 cycle.
  - Decode error: m_ready in the 2nd cycle.
- s_be is passed through for writes; it is driven but don't-care for reads.
- The counter resets to 0 on entry to ACCESS.

Test Plan:
- Reset: hold reset_n=0 with random inputs → all outputs 0. Release → IDLE; no s_cen until m_cen=1.
- Zero-wait read: slave0 acks in the first ACCESS cycle with 0xDEADBEEF; m_addr=0x004 → s_cen=2'b01, s_addr=0x04. m_ready pulses for 1 cycle, 2 cycles after acceptance, with m_rdata=0xDEADBEEF, m_err=0.
- Wait-state write: m_addr=0x120, m_be=4'b0011, m_wdata=0x12345678; slave1 acks after 4 cycles → s_cen=2'b10, s_wen=1, s_be=0011 held for 4 cycles. Then m_ready=1, m_err=0.
- Timeout: slave0 never acks, TIMEOUT=15 → s_cen high exactly 15 cycles, then m_ready=1, m_err=1, m_rdata=0. Also drive s_ack in cycle 15 → normal completion, m_err=0.
- Decode error: N_SLV=2, m_addr=0x300 → no s_cen ever asserted; m_ready in the 2nd cycle with m_err=1. Separately, drive s_ack[1] while slave0 is selected → it is ignored.
- Reset mid-ACCESS: pull reset_n low during a wait state → s_cen drops immediately (async); no m_ready is issued after release.
